msrv32_wb_ctrl: RTL and testbench
=================================

# msrv32_wb_ctrl

Writeback-stage controller for the msrv32 RV32I core. It latches the decode-stage writeback controls into stage-2 registers and drives the select and ALU-source lines of `msrv32_wb_mux_sel_unit`. It sequences loads by holding the pipeline until the data-memory response arrives, with a bounded timeout. It also generates the register-file write enable, the retire pulse and the stall back-pressure to decode, and it squashes the stage on flush.

## Interface
- `LOAD_TIMEOUT`, 16: maximum cycles spent in LOAD_WAIT before the load is abandoned; legal range 1..255.
- `ms_riscv32_mp_clk_in`  in  1  single clock; all state updates on its rising edge.
- `ms_riscv32_mp_rstn_in`  in  1  reset; asynchronous, active-low.
- `valid_in`  in  1  decode presents an instruction.
- `ready_out`  out  1  writeback can accept; the transfer happens when `valid_in && ready_out`.
- `wb_mux_sel_in`  in  3  writeback source code: 000 ALU, 001 LU, 010 IMM, 011 IADDER, 100 CSR, 101 PC+4, 110 RS2.
- `alu_src_in`  in  1  ALU second-operand select (1 = rs2, 0 = imm).
- `rf_wr_en_in`  in  1  instruction writes rd.
- `rd_addr_in`  in  5  destination register.
- `is_load_in`  in  1  instruction is a load.
- `dmem_rvalid_in`  in  1  load data valid this cycle.
- `flush_in`  in  1  trap or taken-branch squash.
- `wb_mux_sel_reg_out`  out  3  registered select to the writeback mux.
- `alu_src_reg_out`  out  1  registered ALU source select.
- `rd_addr_reg_out`  out  5  registered rd address.
- `rf_wr_en_out`  out  1  register-file write strobe.
- `retire_out`  out  1  one-cycle pulse per completed instruction.
- `load_err_out`  out  1  one-cycle pulse when a load times out.

## Operation
- FSM states:
  - IDLE: no instruction in WB.
  - EXEC: non-load instruction in WB.
  - LOAD_WAIT: load in WB, data not yet returned.
- Capture: on `valid_in && ready_out && !flush_in`, the four control fields load into the stage registers.
  - Next state is LOAD_WAIT if `is_load_in`, else EXEC.
  - With no capture, the state goes to IDLE.
- `ready_out = (state != LOAD_WAIT) || dmem_rvalid_in`. This is combinational, so back-to-back issue is possible.
- EXEC:
  - `rf_wr_en_out = rf_wr_en_reg && rd_addr_reg != 0 && !flush_in`.
  - `retire_out = !flush_in`.
- LOAD_WAIT, `dmem_rvalid_in = 1`:
  - Write strobe is asserted under the same x0 and flush gating as EXEC.
  - `retire_out` = 1.
  - Transition follows the capture rule.
- LOAD_WAIT, no rvalid:
  - `wait_cnt` increments.
  - When `wait_cnt == LOAD_TIMEOUT-1` and rvalid is still absent: `load_err_out` = 1, no write, no retire, next state IDLE, `wait_cnt` cleared.
- `wait_cnt` is 8 bits. It clears on entry to LOAD_WAIT and never wraps, because the timeout fires first.
- Flush has priority over every other event:
  - Write and retire are gated off.
  - The incoming instruction is not captured.
  - Next state is IDLE and `wait_cnt` clears.
  - If flush coincides with rvalid, the load is dropped.
  - If flush coincides with the timeout, `load_err_out` stays 0.
- Stage registers hold their value while not capturing. This keeps the mux select stable during LOAD_WAIT.

## Timing
- Reset (async assert; deassert sampled on the next clock edge):
  - State is IDLE.
  - All registered outputs are 0 (select = ALU).
  - `wait_cnt` is 0.
  - `ready_out` = 1 and `rf_wr_en_out`, `retire_out`, `load_err_out` = 0.
- Reset asserted mid-load abandons the load silently, with no error pulse.
- Latency:
  - Non-load: capture edge, then write in the next cycle (1 cycle).
  - Load: write in the same cycle as `dmem_rvalid_in`, at the earliest 1 cycle after capture.
- `rf_wr_en_out`, `retire_out` and `load_err_out` are combinational from state and inputs, and high for at most one cycle per instruction.
- `dmem_rvalid_in` is ignored outside LOAD_WAIT.

## Structure
- Shared package `msrv32_pkg`:
  - `WB_SEL_*` 3-bit constants: ALU, LU, IMM, IADDER, CSR, PC4, RS2.
  - `wb_state_t` enum: IDLE, EXEC, LOAD_WAIT.
- Sub-module `msrv32_wb_load_timer`: an 8-bit counter with clear, enable and `expire` outputs, parameterised by `LOAD_TIMEOUT`.
- The top level instantiates `msrv32_wb_mux_sel_unit` beside this block. This block contains no datapath.

## Test plan
- Non-load, sel=000, rd=5, wr_en=1, captured at cycle 0 → cycle 1: `rf_wr_en_out`=1, `rd_addr_reg_out`=5, `retire_out`=1.
- Load, rd=7, rvalid at cycle 4 → `ready_out`=0 in cycles 1–3 and `wb_mux_sel_reg_out`=001 held. In cycle 4: write=1, retire=1, `ready_out`=1, and a next instruction presented in cycle 4 is captured.
- Load with `LOAD_TIMEOUT`=4, rvalid never arrives → `load_err_out` pulses in the 4th LOAD_WAIT cycle, no write, state IDLE, `ready_out`=1 in the next cycle.
- Non-load with rd=0 and wr_en=1 → `rf_wr_en_out`=0, `retire_out`=1.
- Flush in the same cycle as rvalid while `valid_in`=1 → no write, no retire, no capture, IDLE in the next cycle.
- `ms_riscv32_mp_rstn_in` pulled low mid-clock during LOAD_WAIT → outputs 0 and `ready_out`=1 immediately, with no `load_err_out`.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: writeback source codes and writeback-stage states.
package msrv32_pkg;

   // Writeback mux source select codes
   localparam logic [2:0] WB_SEL_ALU    = 3'b000;
   localparam logic [2:0] WB_SEL_LU     = 3'b001;
   localparam logic [2:0] WB_SEL_IMM    = 3'b010;
   localparam logic [2:0] WB_SEL_IADDER = 3'b011;
   localparam logic [2:0] WB_SEL_CSR    = 3'b100;
   localparam logic [2:0] WB_SEL_PC4    = 3'b101;
   localparam logic [2:0] WB_SEL_RS2    = 3'b110;

   // Width of the load wait counter
   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EXEC      = 2'd1,
      LOAD_WAIT = 2'd2
   } wb_state_t;

endpackage

// File: rtl/msrv32_wb_load_timer.sv
// Load wait counter: counts LOAD_WAIT cycles and flags the last permitted one.
module msrv32_wb_load_timer
   import msrv32_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(LOAD_TIMEOUT - 1);

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   // Clear wins over enable; the owner clears before the count can pass LAST_CNT
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/msrv32_wb_ctrl.sv
// Writeback-stage controller: stage registers, load sequencing with timeout,
// register-file write strobe, retire pulse and stall back-pressure.
module msrv32_wb_ctrl
   import msrv32_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 16
) (
   input  logic       ms_riscv32_mp_clk_in,
   input  logic       ms_riscv32_mp_rstn_in,
   input  logic       valid_in,
   output logic       ready_out,
   input  logic [2:0] wb_mux_sel_in,
   input  logic       alu_src_in,
   input  logic       rf_wr_en_in,
   input  logic [4:0] rd_addr_in,
   input  logic       is_load_in,
   input  logic       dmem_rvalid_in,
   input  logic       flush_in,
   output logic [2:0] wb_mux_sel_reg_out,
   output logic       alu_src_reg_out,
   output logic [4:0] rd_addr_reg_out,
   output logic       rf_wr_en_out,
   output logic       retire_out,
   output logic       load_err_out
);

   wb_state_t  state_q;
   wb_state_t  state_d;
   logic [2:0] wb_sel_q;
   logic       alu_src_q;
   logic       rf_wr_en_q;
   logic [4:0] rd_addr_q;

   logic capture;
   logic complete;
   logic timeout;
   logic expire;
   logic in_load;
   logic timer_clear;
   logic timer_en;

   assign in_load = (state_q == LOAD_WAIT);

   // Handshake, completion, timeout and next-state decode; flush overrides all
   always_comb begin
      ready_out = !in_load || dmem_rvalid_in;
      capture   = valid_in && ready_out && !flush_in;
      complete  = !flush_in && ((state_q == EXEC) || (in_load && dmem_rvalid_in));
      timeout   = in_load && !dmem_rvalid_in && expire && !flush_in;

      state_d = IDLE;
      if (flush_in) begin
         state_d = IDLE;
      end else if (capture) begin
         state_d = is_load_in ? LOAD_WAIT : EXEC;
      end else if (in_load && !dmem_rvalid_in && !timeout) begin
         state_d = LOAD_WAIT;
      end

      rf_wr_en_out = complete && rf_wr_en_q && (rd_addr_q != 5'd0);
      retire_out   = complete;
      load_err_out = timeout;

      // A load captured back-to-back stays in LOAD_WAIT, so capture alone must clear
      timer_clear = capture || (state_d != LOAD_WAIT);
      timer_en    = in_load && !dmem_rvalid_in;
   end

   // State and stage registers; stage fields hold unless a new instruction is taken
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rstn_in) begin
      if (!ms_riscv32_mp_rstn_in) begin
         state_q    <= IDLE;
         wb_sel_q   <= WB_SEL_ALU;
         alu_src_q  <= 1'b0;
         rf_wr_en_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            wb_sel_q   <= wb_mux_sel_in;
            alu_src_q  <= alu_src_in;
            rf_wr_en_q <= rf_wr_en_in;
            rd_addr_q  <= rd_addr_in;
         end
      end
   end

   msrv32_wb_load_timer #(
      .LOAD_TIMEOUT(LOAD_TIMEOUT)
   ) u_load_timer (
      .clk_i    (ms_riscv32_mp_clk_in),
      .rst_ni   (ms_riscv32_mp_rstn_in),
      .clear_i  (timer_clear),
      .en_i     (timer_en),
      .expire_o (expire)
   );

   assign wb_mux_sel_reg_out = wb_sel_q;
   assign alu_src_reg_out    = alu_src_q;
   assign rd_addr_reg_out    = rd_addr_q;

endmodule

// File: tb/tb_msrv32_wb_ctrl.sv
// Directed bench for msrv32_wb_ctrl with a small expected-result queue.
module tb_msrv32_wb_ctrl;

   logic       clk;
   logic       rst_n;
   logic       valid_in;
   logic       ready_out;
   logic [2:0] wb_mux_sel_in;
   logic       alu_src_in;
   logic       rf_wr_en_in;
   logic [4:0] rd_addr_in;
   logic       is_load_in;
   logic       dmem_rvalid_in;
   logic       flush_in;
   logic [2:0] wb_mux_sel_reg_out;
   logic       alu_src_reg_out;
   logic [4:0] rd_addr_reg_out;
   logic       rf_wr_en_out;
   logic       retire_out;
   logic       load_err_out;

   typedef struct packed {
      logic       ready;
      logic       wr;
      logic       ret;
      logic       err;
      logic [2:0] sel;
      logic       alu;
      logic [4:0] rd;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   msrv32_wb_ctrl #(
      .LOAD_TIMEOUT(4)
   ) dut (
      .ms_riscv32_mp_clk_in  (clk),
      .ms_riscv32_mp_rstn_in (rst_n),
      .valid_in              (valid_in),
      .ready_out             (ready_out),
      .wb_mux_sel_in         (wb_mux_sel_in),
      .alu_src_in            (alu_src_in),
      .rf_wr_en_in           (rf_wr_en_in),
      .rd_addr_in            (rd_addr_in),
      .is_load_in            (is_load_in),
      .dmem_rvalid_in        (dmem_rvalid_in),
      .flush_in              (flush_in),
      .wb_mux_sel_reg_out    (wb_mux_sel_reg_out),
      .alu_src_reg_out       (alu_src_reg_out),
      .rd_addr_reg_out       (rd_addr_reg_out),
      .rf_wr_en_out          (rf_wr_en_out),
      .retire_out            (retire_out),
      .load_err_out          (load_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] sel, input logic alu,
                        input logic wr, input logic [4:0] rd, input logic ld,
                        input logic rv, input logic fl);
      valid_in       = v;
      wb_mux_sel_in  = sel;
      alu_src_in     = alu;
      rf_wr_en_in    = wr;
      rd_addr_in     = rd;
      is_load_in     = ld;
      dmem_rvalid_in = rv;
      flush_in       = fl;
   endtask

   task automatic push(input string tag, input logic ready, input logic wr,
                       input logic ret, input logic err, input logic [2:0] sel,
                       input logic alu, input logic [4:0] rd);
      exp_t e;
      e.ready = ready; e.wr = wr; e.ret = ret; e.err = err;
      e.sel = sel; e.alu = alu; e.rd = rd;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_compare();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (ready_out === e.ready) else begin
         n_err++; $error("FAIL %s ready_out obs=%0b exp=%0b", t, ready_out, e.ready);
      end
      n_cmp++;
      assert (rf_wr_en_out === e.wr) else begin
         n_err++; $error("FAIL %s rf_wr_en_out obs=%0b exp=%0b", t, rf_wr_en_out, e.wr);
      end
      n_cmp++;
      assert (retire_out === e.ret) else begin
         n_err++; $error("FAIL %s retire_out obs=%0b exp=%0b", t, retire_out, e.ret);
      end
      n_cmp++;
      assert (load_err_out === e.err) else begin
         n_err++; $error("FAIL %s load_err_out obs=%0b exp=%0b", t, load_err_out, e.err);
      end
      n_cmp++;
      assert (wb_mux_sel_reg_out === e.sel) else begin
         n_err++; $error("FAIL %s wb_mux_sel_reg_out obs=%0b exp=%0b", t, wb_mux_sel_reg_out, e.sel);
      end
      n_cmp++;
      assert (alu_src_reg_out === e.alu) else begin
         n_err++; $error("FAIL %s alu_src_reg_out obs=%0b exp=%0b", t, alu_src_reg_out, e.alu);
      end
      n_cmp++;
      assert (rd_addr_reg_out === e.rd) else begin
         n_err++; $error("FAIL %s rd_addr_reg_out obs=%0d exp=%0d", t, rd_addr_reg_out, e.rd);
      end
   endtask

   // Inputs are already applied at a falling edge; check mid-cycle, then advance.
   task automatic step(input string tag, input logic ready, input logic wr,
                       input logic ret, input logic err, input logic [2:0] sel,
                       input logic alu, input logic [4:0] rd);
      push(tag, ready, wr, ret, err, sel, alu, rd);
      #2;
      pop_compare();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
      rst_n = 1'b1;

      // Non-load rd=5: capture then write/retire one cycle later
      drive(1'b1, 3'b000, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      step("nl_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("nl_wb", 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 5'd5);

      // Load rd=7, rvalid in the 4th cycle, next instruction taken that cycle
      drive(1'b1, 3'b001, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      step("ld_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5);
      drive(1'b1, 3'b010, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
      step("ld_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd7);
      step("ld_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd7);
      step("ld_wait3", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd7);
      drive(1'b1, 3'b010, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
      step("ld_done", 1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 5'd7);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("b2b_wb", 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd9);

      // Non-load to x0: retires without a write
      drive(1'b1, 3'b100, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      step("x0_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd9);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("x0_wb", 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 5'd0);

      // Load timeout (LOAD_TIMEOUT=4): error in the 4th wait cycle
      drive(1'b1, 3'b001, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      step("to_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 5'd0);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("to_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd3);
      step("to_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd3);
      step("to_wait3", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd3);
      step("to_fire", 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 5'd3);
      step("to_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd3);

      // Flush coinciding with rvalid and a presented instruction
      drive(1'b1, 3'b001, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
      step("fl_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd3);
      drive(1'b1, 3'b101, 1'b1, 1'b1, 5'd20, 1'b0, 1'b1, 1'b1);
      step("fl_rv", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd12);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("fl_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd12);

      // Flush coinciding with the timeout cycle suppresses the error
      drive(1'b1, 3'b001, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
      step("flto_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 5'd12);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("flto_w1", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd14);
      step("flto_w2", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd14);
      step("flto_w3", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd14);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step("flto_fire", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd14);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("flto_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd14);

      // Flush of a non-load in EXEC
      drive(1'b1, 3'b110, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
      step("flex_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd14);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step("flex_exec", 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 5'd2);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("flex_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 5'd2);

      // Asynchronous reset in the middle of a load wait
      drive(1'b1, 3'b001, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      step("rst_cap", 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 5'd2);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("rst_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd6);
      step("rst_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 5'd6);
      #1 rst_n = 1'b0;
      push("rst_async", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
      #1;
      pop_compare();
      @(negedge clk);
      step("rst_hold1", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
      step("rst_hold2", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);
      rst_n = 1'b1;
      step("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
